// File: rtl/jace_scandoubler_if.sv
// Video bus between the Ace pixel generator (master) and the scan doubler (slave).
// Carries the 15.6 kHz input stream and the doubled-rate 31.2 kHz output.
interface jace_scandoubler_if;
  logic pix_ce;
  logic r_in;
  logic g_in;
  logic b_in;
  logic hsync_in;
  logic vsync_in;
  logic scanlines;
  logic r_out;
  logic g_out;
  logic b_out;
  logic hsync_out;
  logic vsync_out;

  modport master (
    output pix_ce, r_in, g_in, b_in, hsync_in, vsync_in, scanlines,
    input  r_out, g_out, b_out, hsync_out, vsync_out
  );

  modport slave (
    input  pix_ce, r_in, g_in, b_in, hsync_in, vsync_in, scanlines,
    output r_out, g_out, b_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/jace_scandoubler.sv
// Line-doubling scan converter: each input line is captured into one bank of a
// ping-pong buffer and replayed twice at the full clk rate from the other bank.
module jace_scandoubler #(
  parameter int HTOTAL   = 416,
  parameter int ADDR_W   = 9,
  parameter int HS_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  jace_scandoubler_if.slave vid
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] X_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] HS_END = ADDR_W'(HS_WIDTH);
  localparam logic [ADDR_W:0]   LEN_RST = (ADDR_W + 1)'(HTOTAL);

  logic [2:0]        line_buf [0:2*DEPTH-1];

  logic [ADDR_W-1:0] wr_x;
  logic              wr_bank;
  logic [ADDR_W:0]   line_len;
  logic              hs_hist;
  logic              line_start;

  logic [ADDR_W-1:0] rd_x;
  logic              pass;

  logic [2:0]        ram_q_p1;
  logic [ADDR_W-1:0] rd_x_p1;
  logic              pass_p1;
  logic              vs_p0;
  logic              vs_p1;

  assign line_start = vid.pix_ce && hs_hist && !vid.hsync_in;

  // Write stage: capture at the input pixel rate
  always_ff @(posedge clk) begin
    if (reset_n && vid.pix_ce)
      line_buf[{wr_bank, wr_x}] <= {vid.g_in, vid.r_in, vid.b_in};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_x     <= '0;
      wr_bank  <= 1'b0;
      line_len <= LEN_RST;
      hs_hist  <= 1'b1;
    end else if (vid.pix_ce) begin
      hs_hist <= vid.hsync_in;
      if (line_start) begin
        line_len <= {1'b0, wr_x} + 1'b1;
        wr_x     <= '0;
        wr_bank  <= ~wr_bank;
      end else if (wr_x != X_MAX) begin
        // a missing hsync parks on the last location rather than wrapping
        wr_x <= wr_x + 1'b1;
      end
    end
  end

  // Read stage p0: replay address, restarted on every input line start
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_x <= '0;
      pass <= 1'b0;
    end else if (line_start) begin
      rd_x <= '0;
      pass <= 1'b0;
    end else if ({1'b0, rd_x} == line_len - 1'b1) begin
      rd_x <= '0;
      pass <= ~pass;
    end else begin
      rd_x <= rd_x + 1'b1;
    end
  end

  // Stage p1: synchronous RAM read, with timing info travelling alongside
  always_ff @(posedge clk) begin
    ram_q_p1 <= line_buf[{~wr_bank, rd_x}];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_x_p1 <= '1;
      pass_p1 <= 1'b0;
      vs_p0   <= 1'b1;
      vs_p1   <= 1'b1;
    end else begin
      rd_x_p1 <= rd_x;
      pass_p1 <= pass;
      vs_p0   <= vid.vsync_in;
      vs_p1   <= vs_p0;
    end
  end

  // Stage p2: registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {vid.g_out, vid.r_out, vid.b_out} <= 3'b000;
      vid.hsync_out <= 1'b1;
      vid.vsync_out <= 1'b1;
    end else begin
      {vid.g_out, vid.r_out, vid.b_out} <= (vid.scanlines && pass_p1) ? 3'b000 : ram_q_p1;
      vid.hsync_out <= !(rd_x_p1 < HS_END);
      vid.vsync_out <= vs_p1;
    end
  end

endmodule

// File: tb/tb_jace_scandoubler.sv
// Randomised scoreboard bench for jace_scandoubler: a line-level reference model
// queues the expected output for every clk, a negedge monitor pops and compares.
module tb_jace_scandoubler;
  localparam int HTOTAL   = 416;
  localparam int ADDR_W   = 9;
  localparam int HS_WIDTH = 32;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  jace_scandoubler_if vid ();

  jace_scandoubler #(.HTOTAL(HTOTAL), .ADDR_W(ADDR_W), .HS_WIDTH(HS_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vid     (vid)
  );

  typedef struct packed {
    logic       known;
    logic [2:0] grb;
    logic       hs;
    logic       vs;
  } exp_t;

  typedef struct {
    int         pos;
    bit         pass;
    bit         known;
    logic [2:0] data;
    bit         vs;
    bit         rst;
  } snap_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  logic [2:0] mem   [2][DEPTH];
  bit         known [2][DEPTH];
  int         wr_x, bank, line_len, sync_edge, edge_n;
  bit         hs_hist;
  snap_t      hist [3];

  // Reference model: capture follows the line-start rules, replay position is
  // simply the clk count since the last resync, modulo the current line length.
  task automatic model_edge();
    snap_t s;
    exp_t  x;
    bit    rst;
    rst = !reset_n;
    edge_n++;
    if (rst) begin
      wr_x = 0; bank = 0; line_len = HTOTAL; sync_edge = edge_n; hs_hist = 1'b1;
    end else if (vid.pix_ce) begin
      mem[bank][wr_x]   = {vid.g_in, vid.r_in, vid.b_in};
      known[bank][wr_x] = 1'b1;
      if (hs_hist && !vid.hsync_in) begin
        line_len = wr_x + 1; wr_x = 0; bank ^= 1; sync_edge = edge_n;
      end else if (wr_x < DEPTH - 1) begin
        wr_x++;
      end
      hs_hist = vid.hsync_in;
    end
    s.pos   = (edge_n - sync_edge) % line_len;
    s.pass  = (((edge_n - sync_edge) / line_len) % 2) == 1;
    s.known = known[1-bank][s.pos];
    s.data  = mem[1-bank][s.pos];
    s.vs    = rst ? 1'b1 : vid.vsync_in;
    s.rst   = rst;
    hist[0] = hist[1];
    hist[1] = hist[2];
    hist[2] = s;

    if (rst) begin
      x = {1'b1, 3'b000, 1'b1, 1'b1};
    end else if (hist[1].rst) begin
      x = {1'b0, 3'b000, 1'b1, 1'b1};
    end else begin
      x.hs = !(hist[0].pos < HS_WIDTH);
      x.vs = hist[0].vs;
      if (vid.scanlines && hist[0].pass) begin
        x.known = 1'b1; x.grb = 3'b000;
      end else begin
        x.known = hist[0].known; x.grb = hist[0].data;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic pixel(input logic [2:0] grb, input bit hs, input bit vs);
    vid.pix_ce = 1'b1;
    {vid.g_in, vid.r_in, vid.b_in} = grb;
    vid.hsync_in = hs;
    vid.vsync_in = vs;
    step();
    vid.pix_ce = 1'b0;
    step();
  endtask

  task automatic send_line(input int len, input bit rnd, input logic [2:0] col, input bit vs);
    for (int p = 0; p < len; p++)
      pixel(rnd ? 3'($urandom) : col, !(p < 30), vs);
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s t=%0t got %b want %b", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("hsync_out", {2'b00, vid.hsync_out}, {2'b00, e.hs});
      chk("vsync_out", {2'b00, vid.vsync_out}, {2'b00, e.vs});
      if (e.known)
        chk("grb_out", {vid.g_out, vid.r_out, vid.b_out}, e.grb);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '{0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1};
    edge_n = 0; wr_x = 0; bank = 0; line_len = HTOTAL; sync_edge = 0; hs_hist = 1'b1;
    vid.pix_ce = 1'b0; vid.r_in = 1'b0; vid.g_in = 1'b0; vid.b_in = 1'b0;
    vid.hsync_in = 1'b1; vid.vsync_in = 1'b1; vid.scanlines = 1'b0;
    reset_n = 1'b0;

    repeat (4) step();
    reset_n = 1'b1;

    // steady lines, then solid-colour pairs without and with scanlines
    send_line(416, 1'b1, 3'b000, 1'b1);
    send_line(416, 1'b0, 3'b100, 1'b1);
    send_line(416, 1'b0, 3'b011, 1'b1);
    send_line(416, 1'b0, 3'b100, 1'b1);
    vid.scanlines = 1'b1;
    send_line(416, 1'b0, 3'b011, 1'b1);
    send_line(416, 1'b0, 3'b100, 1'b1);
    vid.scanlines = 1'b0;

    // short line, then a line with hsync missing long enough to saturate
    send_line(400, 1'b1, 3'b000, 1'b1);
    send_line(416, 1'b1, 3'b000, 1'b1);
    send_line(416, 1'b1, 3'b000, 1'b1);
    send_line(640, 1'b1, 3'b000, 1'b1);
    send_line(416, 1'b1, 3'b000, 1'b1);
    send_line(416, 1'b1, 3'b000, 1'b1);

    // field sync spanning 8 lines
    for (int l = 0; l < 10; l++)
      send_line(416, 1'b1, 3'b000, !(l >= 1 && l <= 8));

    // random lengths and scanline setting
    for (int l = 0; l < 8; l++) begin
      vid.scanlines = 1'($urandom);
      send_line(380 + int'($urandom_range(0, 60)), 1'b1, 3'b000, 1'($urandom_range(0, 3) != 0));
    end
    vid.scanlines = 1'b0;

    // reset asserted mid-line
    send_line(200, 1'b1, 3'b000, 1'b1);
    reset_n = 1'b0;
    pixel(3'b111, 1'b1, 1'b1);
    pixel(3'b111, 1'b1, 1'b1);
    reset_n = 1'b1;
    send_line(416, 1'b1, 3'b000, 1'b1);
    send_line(416, 1'b1, 3'b000, 1'b1);
    send_line(416, 1'b1, 3'b000, 1'b1);

    #20;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
